// File: rtl/truth_table_scanner_if.sv
// truth_table_scanner_if: start/result bus between a controller and the scanner, plus the stimulus/response pins of the block under test.
interface truth_table_scanner_if;
    logic        start;
    logic [15:0] expected;
    logic        x1, x2, x3, x4;
    logic        f;
    logic        busy;
    logic        done;
    logic [15:0] table_out;
    logic        pass;
    logic [4:0]  mismatch_cnt;
    logic [3:0]  first_fail;
    logic        fail_valid;
    modport master (
        output start, expected, f,
        input  x1, x2, x3, x4, busy, done, table_out, pass, mismatch_cnt, first_fail, fail_valid
    );
    modport slave (
        input  start, expected, f,
        output x1, x2, x3, x4, busy, done, table_out, pass, mismatch_cnt, first_fail, fail_valid
    );
endinterface

// File: rtl/truth_table_scanner.sv
// truth_table_scanner: steps a 4-input block through all 16 combinations, captures f into a truth table
// and grades it against an expected table latched at start.
module truth_table_scanner #(
    parameter int SETTLE = 2
) (
    input logic clk,
    input logic rst,
    truth_table_scanner_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    localparam logic [3:0] SET = 4'(SETTLE);
    state_t      state, state_n;
    logic [3:0]  idx, idx_n, hold, hold_n, ff, ff_n;
    logic [15:0] exp_q, exp_n, tbl, tbl_n, tbl_s;
    logic [4:0]  cnt, cnt_n;
    logic        fv, fv_n, pass_q, pass_n, busy_q, busy_n, done_q, done_n;
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            hold   <= '0;
            exp_q  <= '0;
            tbl    <= '0;
            cnt    <= '0;
            ff     <= '0;
            fv     <= 1'b0;
            pass_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            idx    <= idx_n;
            hold   <= hold_n;
            exp_q  <= exp_n;
            tbl    <= tbl_n;
            cnt    <= cnt_n;
            ff     <= ff_n;
            fv     <= fv_n;
            pass_q <= pass_n;
            busy_q <= busy_n;
            done_q <= done_n;
        end
    end
    always_comb begin
        state_n = state;
        idx_n   = idx;
        hold_n  = hold;
        exp_n   = exp_q;
        tbl_n   = tbl;
        cnt_n   = cnt;
        ff_n    = ff;
        fv_n    = fv;
        pass_n  = pass_q;
        busy_n  = busy_q;
        done_n  = 1'b0;
        tbl_s   = tbl;
        tbl_s[idx] = bus.f;
        case (state)
            IDLE: if (bus.start) begin
                idx_n   = '0;
                hold_n  = '0;
                exp_n   = bus.expected;
                tbl_n   = '0;
                cnt_n   = '0;
                ff_n    = '0;
                fv_n    = 1'b0;
                pass_n  = 1'b0;
                busy_n  = 1'b1;
                state_n = SCAN;
            end
            SCAN: if (hold != SET) begin
                hold_n = hold + 4'd1;
            end else begin
                tbl_n  = tbl_s;
                hold_n = '0;
                if (bus.f != exp_q[idx]) begin
                    cnt_n = cnt + 5'd1;
                    ff_n  = fv ? ff : idx;
                    fv_n  = 1'b1;
                end
                // pass uses the table including the bit sampled on this edge
                if (idx == 4'd15) begin
                    state_n = DONE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    pass_n  = (tbl_s == exp_q);
                end else begin
                    idx_n = idx + 4'd1;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    assign {bus.x1, bus.x2, bus.x3, bus.x4} = idx;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.table_out    = tbl;
    assign bus.pass         = pass_q;
    assign bus.mismatch_cnt = cnt;
    assign bus.first_fail   = ff;
    assign bus.fail_valid   = fv;
endmodule

// File: doc/truth_table_scanner.md
Name: truth_table_scanner

Overview:
Sequencer that drives a 4-input combinational block (x1..x4 -> f) through all 16 input combinations in ascending order. It captures f for each combination into a 16-bit truth table and compares the table against an expected value. It replaces hand-written per-vector stimulus with one self-checking, start/done-controlled scan. It sits between a top-level controller (or bench) and the combinational block under test.

Parameters:
SETTLE, 2, extra hold cycles per vector before f is sampled (0..15); each vector is held SETTLE+1 cycles.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  scan request; acted on only in IDLE
expected  input  16  expected truth table; bit i = expected f for index i; sampled at the start-accept edge
x1  output  1  stimulus MSB (index bit 3)
x2  output  1  stimulus, index bit 2
x3  output  1  stimulus, index bit 1
x4  output  1  stimulus LSB (index bit 0)
f  input  1  combinational response of the block under test
busy  output  1  high while a scan is running
done  output  1  one-cycle pulse when a scan completes
table_out  output  16  captured truth table; bit i = f sampled at index i
pass  output  1  table_out == expected latch; valid when done, held afterwards
mismatch_cnt  output  5  number of differing bits, 0..16
first_fail  output  4  lowest mismatching index; 0 when there is no mismatch
fail_valid  output  1  at least one mismatch

Behaviour:
- Reset (rst=1 at an edge): state=IDLE. x1..x4=0, busy=0, done=0, table_out=0, pass=0, mismatch_cnt=0, first_fail=0, fail_valid=0. Reset overrides everything, including mid-scan; the partial results are discarded.
- Registers:
  - idx[3:0] drives {x1,x2,x3,x4} directly (registered outputs).
  - hold counter, 4 bits.
  - exp_q, 16 bits, latched from expected.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - If start=1 at edge E0: idx<=0, hold<=0, exp_q<=expected. Clear table_out, mismatch_cnt, first_fail, fail_valid and pass. Set busy<=1 and go to SCAN.
  - Otherwise all outputs hold their values; previous results stay visible.
- SCAN, at each edge:
  - If hold != SETTLE: hold<=hold+1.
  - Else (sample edge):
    - table_out[idx] <= f.
    - If f != exp_q[idx]: mismatch_cnt<=mismatch_cnt+1. If fail_valid==0, also set first_fail<=idx and fail_valid<=1.
    - hold<=0.
    - If idx==15: go to DONE, busy<=0, done<=1, and pass <= (final table == exp_q), computed including this last bit.
    - Else: idx<=idx+1. idx never wraps inside a scan.
- DONE: lasts one cycle. done<=0 and go to IDLE; idx stays at 15.
- Timing:
  - Sample k (k=0..15) occurs at edge E0+(k+1)(SETTLE+1).
  - done is high in the single cycle following edge E0+16(SETTLE+1); busy is low in that cycle.
  - With SETTLE=2 the last sample is at E0+48.
- Boundary cases:
  - start while busy or in DONE is ignored, with no restart or queuing.
  - start held high continuously gives back-to-back scans with one IDLE cycle between them.
  - A change on expected during a scan has no effect.
  - SETTLE=0 gives one cycle per vector and a 16-cycle scan.
  - mismatch_cnt reaches 16 without overflow.
- Results stay stable from the done cycle until the next accepted start, or until reset.

Test Plan:
- Bench model f = x1^x2^x3^x4, SETTLE=2, expected=16'h6996, start pulse at E0 -> done exactly one cycle after edge E0+48. Required: table_out=16'h6996, pass=1, mismatch_cnt=0, fail_valid=0, first_fail=0, busy high from E0 through E0+48.
- Same model, expected=16'h6997 -> mismatch_cnt=1, first_fail=0, fail_valid=1, pass=0. Stimulus {x1..x4} must step 0,1,...,15, each held 3 cycles.
- Model f = x1&x2 | x3&x4, expected=16'h0000 -> table_out=16'hF888, mismatch_cnt=7, first_fail=3, pass=0.
- rst=1 asserted at edge E0+20, then a new start -> outputs return to reset values at E0+20, and the new scan yields correct, unpolluted results.
- start pulsed again at E0+10 and at the done cycle -> both are ignored, done pulses once; a start one cycle after done begins a new scan.
- SETTLE=0, parity model, start held high -> scans complete every 18 cycles (16 SCAN + DONE + IDLE), each with pass=1.
